cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Consumer end of the execution-unit-to-CDB handshake.
- Collects completed results from N execution units (ALU, MUL/DIV, LSU, branch) that each hold one result with `req` high until accepted.
- Picks at most one winner per cycle by round-robin and returns `rdy` to the winner.
- Broadcasts the winner's tag and data on the common data bus one cycle later, for the reservation stations and ROB to snoop.

Parameters:
- N_EXU, 4, number of execution-unit requesters (2..8).
- TAG_W, 4, width of the ROB/physical tag.
- DATA_W, 32, result width.
- SRC_W, $clog2(N_EXU), width of the source-index output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- exu_req  in  N_EXU  per-unit result-valid; held high with stable tag/data until accepted.
- exu_tag  in  N_EXU*TAG_W  per-unit tag; unit i occupies bits [i*TAG_W +: TAG_W].
- exu_wdata  in  N_EXU*DATA_W  per-unit result; unit i occupies [i*DATA_W +: DATA_W].
- exu_rdy  out  N_EXU  per-unit accept; one-hot or zero; combinational.
- cdb_vld  out  1  broadcast valid, registered.
- cdb_tag  out  TAG_W  broadcast tag, registered.
- cdb_data  out  DATA_W  broadcast result, registered.
- cdb_src  out  SRC_W  index of the unit that produced the current broadcast, registered.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
  - On `rst_n` low: cdb_vld=0, cdb_tag=0, cdb_data=0, cdb_src=0, rr_ptr=0.
  - Because exu_rdy is combinational, it is 0 whenever all exu_req are 0.
- Handshake: transfer from unit i occurs at a rising edge where exu_req[i] && exu_rdy[i]. The unit may deassert req or present a new result in the following cycle, which matches the EXU output-register convention.
- Grant logic (combinational):
  - Search exu_req starting at index rr_ptr, increasing modulo N_EXU.
  - The first requester found is granted: exu_rdy[that]=1, all other bits 0.
  - exu_rdy[i] is never 1 while exu_req[i]=0.
  - exu_rdy has no combinational dependence on any output of this block other than rr_ptr.
- No backpressure: the CDB always accepts, so a grant is issued every cycle at least one req is high. Throughput is one result per cycle.
- Pointer update: on a transfer from unit g, rr_ptr <= (g+1) mod N_EXU. With no transfer, rr_ptr holds.
- Wrap-around: with g=N_EXU-1, rr_ptr returns to 0.
- Fairness: a continuously requesting unit is granted within N_EXU cycles.
- Broadcast register, every cycle:
  - cdb_vld <= |exu_rdy.
  - If a grant exists: cdb_tag, cdb_data and cdb_src load the winner's tag, wdata and index.
  - Otherwise cdb_tag and cdb_data are cleared to 0, and cdb_src holds.
  - Latency: transfer edge T gives broadcast visible in cycle T+1, valid for exactly one cycle per result.
- Back-to-back: consecutive cycles with grants produce consecutive cdb_vld=1 cycles with no bubble.
- Single requester: the same unit may win on successive cycles if it is the only one requesting, e.g. it re-raises req immediately after transfer.
- Simultaneous events: all N_EXU requesting in one cycle gives exactly one grant. The others stay pending and keep their req and data stable.
- Reset mid-operation: an in-flight broadcast is dropped, and pending exu_req are re-arbitrated from rr_ptr=0 after release.
- Assertions:
  - exu_rdy is one-hot0.
  - exu_rdy implies exu_req.
  - cdb_vld never rises in the cycle after a cycle with no grant.

Test Plan:
- Reset then idle: rst_n pulse low for 3 cycles, all exu_req=0 for 10 cycles -> cdb_vld=0, exu_rdy=0, cdb_tag=0 throughout.
- Single unit: unit 2 raises req with tag=5, wdata=0xDEADBEEF -> exu_rdy=4'b0100 the same cycle. Next cycle cdb_vld=1, cdb_tag=5, cdb_data=0xDEADBEEF, cdb_src=2. One cycle after that, cdb_vld=0.
- All four units request continuously with distinct tags 1..4 -> grants in order 0,1,2,3,0,… with rr_ptr wrapping. cdb_vld stays high every cycle, and cdb_src sequence 0,1,2,3,0 is offset by one cycle.
- Partial contention: rr_ptr=3, units 1 and 3 request -> unit 3 wins first, then unit 1, then rr_ptr=2.
- Held request: unit 0 and unit 1 both request, unit 1 keeps req high for 2 cycles -> unit 1's tag and data are broadcast exactly once, in the cycle after its exu_rdy.
- Async reset mid-burst: assert rst_n low between clock edges during back-to-back broadcasts -> cdb_vld drops to 0 immediately, without waiting for an edge. After release, arbitration restarts from unit 0.

Source files
------------

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : cdb_arbiter
//  Purpose  : Common-data-bus arbiter. Collects completed results from
//             N_EXU execution units, picks one per cycle by round-robin,
//             returns a combinational accept to the winner and broadcasts
//             the winner's tag/data on the CDB one cycle later.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             exu_req   [N_EXU]          - per-unit result valid (held)
//             exu_tag   [N_EXU*TAG_W]    - per-unit tag, unit i at i*TAG_W
//             exu_wdata [N_EXU*DATA_W]   - per-unit result, unit i at i*DATA_W
//             exu_rdy   [N_EXU]          - per-unit accept, one-hot0, comb.
//             cdb_vld/cdb_tag/cdb_data   - registered broadcast
//             cdb_src   [SRC_W]          - index of the broadcasting unit
//  Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int N_EXU  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int SRC_W  = $clog2(N_EXU)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_EXU-1:0]        exu_req,
  input  logic [N_EXU*TAG_W-1:0]  exu_tag,
  input  logic [N_EXU*DATA_W-1:0] exu_wdata,
  output logic [N_EXU-1:0]        exu_rdy,
  output logic                    cdb_vld,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [SRC_W-1:0]        cdb_src
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_EXU - 1);

  logic [SRC_W-1:0]  rr_ptr_q,   rr_ptr_d;
  logic              cdb_vld_q,  cdb_vld_d;
  logic [TAG_W-1:0]  cdb_tag_q,  cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]  cdb_src_q,  cdb_src_d;

  logic [N_EXU-1:0]  grant;
  logic              grant_any;
  logic [SRC_W-1:0]  grant_idx;

  // Round-robin search: scan requesters starting at rr_ptr, wrapping at
  // N_EXU. rr_ptr only ever holds 0..N_EXU-1, so a single subtraction is
  // enough to bring the candidate index back into range.
  always_comb begin
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < N_EXU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_EXU) begin
        idx = idx - N_EXU;
      end
      if (!grant_any && exu_req[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = idx[SRC_W-1:0];
        grant[idx] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner; with no transfer it holds.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // Broadcast stage: tag/data clear when idle, source index is sticky.
  always_comb begin
    cdb_vld_d  = grant_any;
    cdb_tag_d  = '0;
    cdb_data_d = '0;
    cdb_src_d  = cdb_src_q;
    if (grant_any) begin
      cdb_tag_d  = exu_tag[grant_idx*TAG_W +: TAG_W];
      cdb_data_d = exu_wdata[grant_idx*DATA_W +: DATA_W];
      cdb_src_d  = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      cdb_vld_q  <= 1'b0;
      cdb_tag_q  <= '0;
      cdb_data_q <= '0;
      cdb_src_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cdb_vld_q  <= cdb_vld_d;
      cdb_tag_q  <= cdb_tag_d;
      cdb_data_q <= cdb_data_d;
      cdb_src_q  <= cdb_src_d;
    end
  end

  assign exu_rdy  = grant;
  assign cdb_vld  = cdb_vld_q;
  assign cdb_tag  = cdb_tag_q;
  assign cdb_data = cdb_data_q;
  assign cdb_src  = cdb_src_q;

endmodule
`default_nettype wire
